// File: rtl/ysyx_22050550_define.sv
// Shared encodings for the multiply controller: op codes, signedness modes, FSM states.
package ysyx_22050550_define;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_MULW   = 3'd4
    } mul_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_HOLD,
        ST_DRAIN
    } mul_state_e;

    localparam logic [1:0] SIGN_SS = 2'b11;
    localparam logic [1:0] SIGN_SU = 2'b10;
    localparam logic [1:0] SIGN_UU = 2'b00;

    function automatic logic [1:0] mul_sign_of(input mul_op_e op);
        case (op)
            OP_MULHSU: return SIGN_SU;
            OP_MULHU:  return SIGN_UU;
            default:   return SIGN_SS;
        endcase
    endfunction

endpackage

// File: rtl/ysyx_22050550_mul_ctrl.sv
// Sequences one multiply op between the EXU, an external multiplier and the WBU,
// with flush draining of in-flight products and a zero-operand shortcut.
module ysyx_22050550_mul_ctrl
    import ysyx_22050550_define::*;
#(
    parameter int XLEN = 64,
    parameter int OPW  = 3
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [OPW-1:0]  in_op,
    input  logic [XLEN-1:0] in_src1,
    input  logic [XLEN-1:0] in_src2,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic            mul_valid,
    input  logic            mul_ready,
    output logic            mul_w,
    output logic [1:0]      mul_signed,
    output logic [XLEN-1:0] mul_multiplicand,
    output logic [XLEN-1:0] mul_multiplier,
    input  logic            mul_out_valid,
    input  logic [XLEN-1:0] mul_result_h,
    input  logic [XLEN-1:0] mul_result_l
);

    mul_state_e      state, state_n;
    mul_op_e         op_q, op_dec;
    logic            accept, src_zero;
    logic [XLEN-1:0] sel_result;

    assign accept   = (state == ST_IDLE) && in_valid && !flush;
    assign src_zero = (in_src1 == '0) || (in_src2 == '0);

    // Op codes 5..7 fall through to plain MUL.
    always_comb begin
        op_dec = OP_MUL;
        if (in_op == OPW'(OP_MULH))        op_dec = OP_MULH;
        else if (in_op == OPW'(OP_MULHSU)) op_dec = OP_MULHSU;
        else if (in_op == OPW'(OP_MULHU))  op_dec = OP_MULHU;
        else if (in_op == OPW'(OP_MULW))   op_dec = OP_MULW;
    end

    always_comb begin
        case (op_q)
            OP_MULH, OP_MULHSU, OP_MULHU: sel_result = mul_result_h;
            OP_MULW: sel_result = {{(XLEN-32){mul_result_l[31]}}, mul_result_l[31:0]};
            default: sel_result = mul_result_l;
        endcase
    end

    // Flush is evaluated first in every state so it beats any handshake.
    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: begin
                if (accept) state_n = src_zero ? ST_HOLD : ST_ISSUE;
            end
            ST_ISSUE: begin
                if (flush)          state_n = mul_ready ? ST_DRAIN : ST_IDLE;
                else if (mul_ready) state_n = ST_WAIT;
            end
            ST_WAIT: begin
                if (flush)              state_n = mul_out_valid ? ST_IDLE : ST_DRAIN;
                else if (mul_out_valid) state_n = ST_HOLD;
            end
            ST_HOLD: begin
                if (flush || out_ready) state_n = ST_IDLE;
            end
            ST_DRAIN: begin
                if (mul_out_valid) state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state            <= ST_IDLE;
            op_q             <= OP_MUL;
            in_ready         <= 1'b1;
            out_valid        <= 1'b0;
            out_result       <= '0;
            mul_valid        <= 1'b0;
            mul_w            <= 1'b0;
            mul_signed       <= '0;
            mul_multiplicand <= '0;
            mul_multiplier   <= '0;
        end else begin
            state     <= state_n;
            in_ready  <= (state_n == ST_IDLE);
            out_valid <= (state_n == ST_HOLD);
            mul_valid <= (state_n == ST_ISSUE);

            if (accept) begin
                op_q             <= op_dec;
                mul_w            <= (op_dec == OP_MULW);
                mul_signed       <= mul_sign_of(op_dec);
                mul_multiplicand <= in_src1;
                mul_multiplier   <= in_src2;
            end

            // out_result is nonzero only while the result is being offered.
            if (state_n != ST_HOLD)
                out_result <= '0;
            else if (state == ST_WAIT)
                out_result <= sel_result;
            else if (state == ST_IDLE)
                out_result <= '0;
        end
    end

endmodule

// File: tb/tb_ysyx_22050550_mul_ctrl.sv
// Randomized bench for the multiply controller with a behavioural multiplier and result model.
module tb_ysyx_22050550_mul_ctrl;

    logic        clock, reset;
    logic        in_valid, in_ready, flush;
    logic [2:0]  in_op;
    logic [63:0] in_src1, in_src2;
    logic        out_valid, out_ready;
    logic [63:0] out_result;
    logic        mul_valid, mul_ready, mul_w, mul_out_valid;
    logic [1:0]  mul_signed;
    logic [63:0] mul_multiplicand, mul_multiplier, mul_result_h, mul_result_l;

    int n_cmp = 0;
    int n_fail = 0;

    ysyx_22050550_mul_ctrl #(.XLEN(64), .OPW(3)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_src1(in_src1), .in_src2(in_src2), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .mul_valid(mul_valid), .mul_ready(mul_ready), .mul_w(mul_w),
        .mul_signed(mul_signed), .mul_multiplicand(mul_multiplicand),
        .mul_multiplier(mul_multiplier), .mul_out_valid(mul_out_valid),
        .mul_result_h(mul_result_h), .mul_result_l(mul_result_l)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Architectural result of each op, straight from the ISA definition.
    function automatic logic [63:0] ref_mul(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
        logic [127:0] sa, za, sb, zb, p;
        logic [63:0]  r;
        sa = {{64{a[63]}}, a}; za = {64'd0, a};
        sb = {{64{b[63]}}, b}; zb = {64'd0, b};
        case (op)
            3'd1: begin p = sa * sb; r = p[127:64]; end
            3'd2: begin p = sa * zb; r = p[127:64]; end
            3'd3: begin p = za * zb; r = p[127:64]; end
            3'd4: begin p = {96'd0, a[31:0]} * {96'd0, b[31:0]}; r = {{32{p[31]}}, p[31:0]}; end
            default: begin p = za * zb; r = p[63:0]; end
        endcase
        return r;
    endfunction

    // Behavioural multiplier: takes a request, answers after mock_lat cycles (random if 0).
    int          mock_lat = 0;
    bit          mock_stall = 0;
    bit          mock_hold_low = 0;
    bit          mock_busy = 0;
    int          mock_cnt = 0;
    int          mock_hs = 0;
    int          mock_pulses = 0;
    logic        mock_last_w = 0;
    logic [1:0]  mock_last_signed = 0;
    logic [127:0] mock_prod = 0;

    initial begin : mock_mul
        logic [127:0] ea, eb;
        mul_ready = 1'b1; mul_out_valid = 1'b0; mul_result_h = '0; mul_result_l = '0;
        forever begin
            @(posedge clock);
            if (reset && mul_valid && mul_ready && !mock_busy) begin
                if (mul_w) begin
                    ea = mul_signed[1] ? {{96{mul_multiplicand[31]}}, mul_multiplicand[31:0]} : {96'd0, mul_multiplicand[31:0]};
                    eb = mul_signed[0] ? {{96{mul_multiplier[31]}}, mul_multiplier[31:0]} : {96'd0, mul_multiplier[31:0]};
                end else begin
                    ea = mul_signed[1] ? {{64{mul_multiplicand[63]}}, mul_multiplicand} : {64'd0, mul_multiplicand};
                    eb = mul_signed[0] ? {{64{mul_multiplier[63]}}, mul_multiplier} : {64'd0, mul_multiplier};
                end
                mock_prod = ea * eb;
                mock_busy = 1;
                mock_cnt = (mock_lat != 0) ? mock_lat : $urandom_range(1, 5);
                mock_last_w = mul_w;
                mock_last_signed = mul_signed;
                mock_hs++;
            end
            @(negedge clock);
            mul_out_valid = 1'b0;
            if (!reset) begin
                mock_busy = 0;
                mul_ready = 1'b1;
            end else if (mock_busy) begin
                mul_ready = 1'b0;
                mock_cnt--;
                if (mock_cnt == 0) begin
                    mul_out_valid = 1'b1;
                    mul_result_h = mock_prod[127:64];
                    mul_result_l = mock_prod[63:0];
                    mock_busy = 0;
                    mock_pulses++;
                end
            end else begin
                mul_ready = mock_hold_low ? 1'b0 : (mock_stall ? ($urandom_range(0, 2) != 0) : 1'b1);
            end
        end
    end

    bit mv_seen;

    task automatic start_op(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
        int t = 0;
        while (!in_ready && t < 100) begin @(negedge clock); t++; end
        n_cmp++;
        if (!in_ready) begin n_fail++; $display("FAIL accept_timeout: in_ready=%0b required 1", in_ready); end
        in_valid = 1'b1; in_op = op; in_src1 = a; in_src2 = b;
        mv_seen = 0;
        @(negedge clock);
        in_valid = 1'b0; in_src1 = {$urandom, $urandom}; in_src2 = {$urandom, $urandom};
        in_op = 3'($urandom);
    endtask

    task automatic wait_out(output int lat);
        lat = 1;
        while (!out_valid && lat < 300) begin
            mv_seen |= mul_valid;
            n_cmp++;
            if (out_result !== 64'd0) begin n_fail++; $display("FAIL idle_result: out_result=%h required 0", out_result); end
            @(negedge clock); lat++;
        end
        mv_seen |= mul_valid;
        n_cmp++;
        if (!out_valid) begin n_fail++; $display("FAIL result_timeout: out_valid=%0b required 1", out_valid); end
    endtask

    task automatic do_op(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                         input int hold, output logic [63:0] res, output int lat);
        start_op(op, a, b);
        wait_out(lat);
        res = out_result;
        repeat (hold) begin
            @(negedge clock);
            n_cmp++;
            if (out_valid !== 1'b1 || out_result !== res) begin
                n_fail++; $display("FAIL hold_stable: valid=%0b result=%h required 1 %h", out_valid, out_result, res);
            end
        end
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL release: out_valid=%0b in_ready=%0b required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        n_cmp++;
        if ({in_ready, out_valid, mul_valid, mul_w, mul_signed} !== 6'b100000 || out_result !== 64'd0) begin
            n_fail++; $display("FAIL reset_state: rdy=%0b ov=%0b mv=%0b w=%0b s=%b res=%h required 1 0 0 0 00 0",
                               in_ready, out_valid, mul_valid, mul_w, mul_signed, out_result);
        end
    endtask

    task automatic test_directed();
        logic [63:0] r; int lat;
        mock_lat = 0; mock_stall = 0;
        do_op(3'd0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 0, r, lat);
        n_cmp++; if (r !== 64'hFFFF_FFFF_FFFF_FFF1) begin n_fail++; $display("FAIL mul_neg: got %h required fffffffffffffff1", r); end
        do_op(3'd3, '1, '1, 1, r, lat);
        n_cmp++; if (r !== 64'hFFFF_FFFF_FFFF_FFFE) begin n_fail++; $display("FAIL mulhu_max: got %h required fffffffffffffffe", r); end
        do_op(3'd1, '1, '1, 0, r, lat);
        n_cmp++; if (r !== 64'd0) begin n_fail++; $display("FAIL mulh_m1: got %h required 0", r); end
        do_op(3'd4, 64'h7FFF_FFFF, 64'd2, 0, r, lat);
        n_cmp++; if (r !== 64'hFFFF_FFFF_FFFF_FFFE) begin n_fail++; $display("FAIL mulw: got %h required fffffffffffffffe", r); end
        n_cmp++;
        if (mock_last_w !== 1'b1 || mock_last_signed !== 2'b11) begin
            n_fail++; $display("FAIL mulw_ctrl: w=%0b signed=%b required 1 11", mock_last_w, mock_last_signed);
        end
        do_op(3'd2, '1, 64'd2, 0, r, lat);
        n_cmp++; if (mock_last_signed !== 2'b10 || mock_last_w !== 1'b0) begin n_fail++; $display("FAIL mulhsu_ctrl: signed=%b w=%0b required 10 0", mock_last_signed, mock_last_w); end
        n_cmp++; if (r !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_fail++; $display("FAIL mulhsu: got %h required ffffffffffffffff", r); end
    endtask

    task automatic test_zero_shortcut();
        logic [63:0] r; int lat; int hs0;
        hs0 = mock_hs;
        do_op(3'd0, 64'd0, 64'd5, 0, r, lat);
        n_cmp++; if (lat != 1) begin n_fail++; $display("FAIL zero_latency: got %0d required 1", lat); end
        n_cmp++; if (r !== 64'd0) begin n_fail++; $display("FAIL zero_result: got %h required 0", r); end
        n_cmp++; if (mv_seen || mock_hs != hs0) begin n_fail++; $display("FAIL zero_no_mul: mul_valid_seen=%0b handshakes=%0d required 0 0", mv_seen, mock_hs - hs0); end
    endtask

    task automatic test_latency();
        logic [63:0] r, a, b; int lat;
        mock_lat = 3; mock_stall = 0;
        a = {$urandom, $urandom} | 64'd1; b = {$urandom, $urandom} | 64'd1;
        do_op(3'd0, a, b, 0, r, lat);
        n_cmp++; if (lat != 5) begin n_fail++; $display("FAIL latency: got %0d required 5", lat); end
        n_cmp++; if (r !== ref_mul(3'd0, a, b)) begin n_fail++; $display("FAIL latency_result: got %h required %h", r, ref_mul(3'd0, a, b)); end
    endtask

    task automatic test_hold_stable();
        logic [63:0] r; int lat;
        mock_lat = 2;
        do_op(3'd3, 64'hDEAD_BEEF_0000_1234, 64'h1234_5678_9ABC_DEF0, 5, r, lat);
        n_cmp++;
        if (r !== ref_mul(3'd3, 64'hDEAD_BEEF_0000_1234, 64'h1234_5678_9ABC_DEF0)) begin
            n_fail++; $display("FAIL hold_result: got %h required %h", r, ref_mul(3'd3, 64'hDEAD_BEEF_0000_1234, 64'h1234_5678_9ABC_DEF0));
        end
    endtask

    task automatic test_flush_wait();
        int t, p0, lat;
        mock_lat = 12; mock_stall = 0;
        start_op(3'd0, 64'd123, 64'd456);
        t = 0;
        do begin @(negedge clock); #1; t++; end while (!mock_busy && t < 50);
        repeat (5) @(negedge clock);
        #1 flush = 1'b1; in_valid = 1'b1; in_op = 3'd0; in_src1 = 64'd6; in_src2 = 64'd7;
        p0 = mock_pulses;
        @(negedge clock); #1 flush = 1'b0;
        t = 0;
        while (!in_ready && t < 50) begin
            n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL drain_out_valid: got %0b required 0", out_valid); end
            @(negedge clock); #1; t++;
        end
        n_cmp++;
        if (!in_ready || mock_pulses == p0) begin
            n_fail++; $display("FAIL drain_ready: in_ready=%0b stale_pulses=%0d required 1 1", in_ready, mock_pulses - p0);
        end
        mv_seen = 0;
        @(negedge clock); in_valid = 1'b0;
        wait_out(lat);
        n_cmp++; if (out_result !== 64'd42) begin n_fail++; $display("FAIL flush_next: got %h required 2a", out_result); end
        out_ready = 1'b1; @(negedge clock); out_ready = 1'b0;
    endtask

    task automatic test_flush_issue();
        logic [63:0] r; int lat, hs0;
        mock_lat = 2; mock_hold_low = 1;
        repeat (3) @(negedge clock);
        hs0 = mock_hs;
        start_op(3'd1, 64'd99, 64'd77);
        n_cmp++; if (mul_valid !== 1'b1) begin n_fail++; $display("FAIL issue_valid: got %0b required 1", mul_valid); end
        flush = 1'b1; @(negedge clock); flush = 1'b0;
        n_cmp++;
        if (in_ready !== 1'b1 || mul_valid !== 1'b0 || mock_hs != hs0) begin
            n_fail++; $display("FAIL issue_flush: in_ready=%0b mul_valid=%0b hs=%0d required 1 0 0", in_ready, mul_valid, mock_hs - hs0);
        end
        mock_hold_low = 0;
        @(negedge clock);
        do_op(3'd0, 64'd11, 64'd13, 0, r, lat);
        n_cmp++; if (r !== 64'd143) begin n_fail++; $display("FAIL issue_flush_next: got %h required 8f", r); end
    endtask

    task automatic test_flush_pulse();
        logic [63:0] r; int lat, t;
        mock_lat = 4;
        start_op(3'd0, 64'd1000, 64'd1000);
        t = 0;
        do begin @(negedge clock); #1; t++; end while (!mul_out_valid && t < 50);
        flush = 1'b1;
        @(negedge clock); #1 flush = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL wait_flush_pulse: out_valid=%0b in_ready=%0b required 0 1", out_valid, in_ready);
        end
        do_op(3'd0, 64'd5, 64'd9, 0, r, lat);
        n_cmp++; if (r !== 64'd45) begin n_fail++; $display("FAIL pulse_flush_next: got %h required 2d", r); end
    endtask

    task automatic test_flush_hold();
        int lat;
        for (int k = 0; k < 2; k++) begin
            mock_lat = 1;
            start_op(3'd0, 64'd8, 64'd8);
            wait_out(lat);
            flush = 1'b1; out_ready = (k == 1);
            @(negedge clock);
            flush = 1'b0; out_ready = 1'b0;
            n_cmp++;
            if (out_valid !== 1'b0 || out_result !== 64'd0 || in_ready !== 1'b1) begin
                n_fail++; $display("FAIL hold_flush%0d: ov=%0b res=%h rdy=%0b required 0 0 1", k, out_valid, out_result, in_ready);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [63:0] r; int lat, t;
        mock_lat = 10;
        start_op(3'd1, 64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888);
        t = 0;
        do begin @(negedge clock); #1; t++; end while (!mock_busy && t < 50);
        @(negedge clock); @(negedge clock);
        #2 reset = 1'b0;
        #1;
        n_cmp++;
        if ({in_ready, out_valid, mul_valid, mul_w, mul_signed} !== 6'b100000 || out_result !== 64'd0
            || mul_multiplicand !== 64'd0 || mul_multiplier !== 64'd0) begin
            n_fail++; $display("FAIL async_reset: rdy=%0b ov=%0b mv=%0b w=%0b s=%b mcand=%h mplr=%h required 1 0 0 0 00 0 0",
                               in_ready, out_valid, mul_valid, mul_w, mul_signed, mul_multiplicand, mul_multiplier);
        end
        @(negedge clock); @(negedge clock);
        reset = 1'b1;
        mock_lat = 2;
        do_op(3'd3, 64'hFFFF_FFFF_0000_0000, 64'd16, 0, r, lat);
        n_cmp++; if (r !== 64'hF) begin n_fail++; $display("FAIL post_reset: got %h required f", r); end
    endtask

    task automatic test_random();
        logic [63:0] r, a, b, e; logic [2:0] op; int lat;
        mock_lat = 0; mock_stall = 1;
        for (int i = 0; i < 50; i++) begin
            op = 3'($urandom_range(0, 7));
            a = {$urandom, $urandom}; b = {$urandom, $urandom};
            if ($urandom_range(0, 9) == 0) a = '0;
            if ($urandom_range(0, 9) == 0) b = '0;
            if ($urandom_range(0, 5) == 0) a = 64'($signed(32'($urandom_range(0, 20))) - 10);
            e = ref_mul(op, a, b);
            do_op(op, a, b, $urandom_range(0, 3), r, lat);
            n_cmp++;
            if (r !== e) begin n_fail++; $display("FAIL random[%0d] op=%0d a=%h b=%h: got %h required %h", i, op, a, b, r, e); end
        end
        mock_stall = 0;
    endtask

    initial begin
        reset = 1'b0; in_valid = 1'b0; in_op = '0; in_src1 = '0; in_src2 = '0;
        flush = 1'b0; out_ready = 1'b0;
        repeat (3) @(negedge clock);
        test_reset();
        reset = 1'b1;
        @(negedge clock);
        test_directed();
        test_zero_shortcut();
        test_latency();
        test_hold_stable();
        test_flush_wait();
        test_flush_issue();
        test_flush_pulse();
        test_flush_hold();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
